mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_pkg.sv | 25 ++
 rtl/mem_stage_ctrl_if.sv | 35 +++
 rtl/mem_wdog_cnt.sv | 38 +++
 rtl/mem_stage_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_pkg
// Shared definitions for the M-stage memory controller:
//   - DATA_W   : address/data width of the memory bus (16)
//   - WDOG_MAX : watchdog terminal count for an outstanding access (255)
//   - state_t  : controller state encoding (IDLE=1'b0, BUSY=1'b1)
//   - is_mem_req() : true when exactly one of load/store is requested
// -----------------------------------------------------------------------------
package mem_stage_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int WDOG_W = 8;
  localparam logic [WDOG_W-1:0] WDOG_MAX = 8'd255;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // A legal memory request is a load or a store, never both at once.
  function automatic logic is_mem_req(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_if
// Bus between the M-stage controller and data memory.
//   memAddr    : address to memory               (master -> slave)
//   memDataIn  : store data to memory            (master -> slave)
//   memEn      : one-cycle request strobe        (master -> slave)
//   memWr      : write qualifier                 (master -> slave)
//   memDump    : one-cycle dump strobe           (master -> slave)
//   memDataOut : read data                       (slave -> master)
//   memDone    : access complete                 (slave -> master)
//   memStall   : memory cannot accept a request  (slave -> master)
// -----------------------------------------------------------------------------
interface mem_stage_ctrl_if;
  import mem_stage_ctrl_pkg::*;

  logic [DATA_W-1:0] memAddr;
  logic [DATA_W-1:0] memDataIn;
  logic [DATA_W-1:0] memDataOut;
  logic              memEn;
  logic              memWr;
  logic              memDump;
  logic              memDone;
  logic              memStall;

  modport master (
    output memAddr, memDataIn, memEn, memWr, memDump,
    input  memDataOut, memDone, memStall
  );

  modport slave (
    input  memAddr, memDataIn, memEn, memWr, memDump,
    output memDataOut, memDone, memStall
  );

endinterface

// File: rtl/mem_wdog_cnt.sv
// -----------------------------------------------------------------------------
// mem_wdog_cnt
// 8-bit watchdog for an outstanding memory access. Cleared when an access
// goes outstanding, counts once per waiting cycle, and flags terminal count.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   i_clr : clear the count (takes priority over increment)
//   i_inc : advance the count by one
//   o_tc  : count has reached WDOG_MAX
// -----------------------------------------------------------------------------
module mem_wdog_cnt
  import mem_stage_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  logic [WDOG_W-1:0] r_cnt;

  // Count register: clear on new outstanding access, saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_inc && (r_cnt != WDOG_MAX)) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == WDOG_MAX);

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-stage controller: issues loads/stores/dumps from the M stage to data
// memory, stalls the pipeline while an access is outstanding, and returns a
// registered completion (validW/errW/dumpW/memDataW) to writeback.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   validM       : instruction present in M
//   dataAddrM    : data address          wrtDataM : store data
//   readEnM      : load request          memWrtM  : store request
//   createDumpM  : HALT dump request
//   mem          : memory bus (mem_stage_ctrl_if.master)
//   stallM       : freeze X/M and upstream stages
//   memDataW     : registered load data  validW   : completed M-stage op
//   errW         : access error          dumpW    : dump issued
//
// Build option: define MEM_ALIGN_CHECK_EN to reject loads/stores with an odd
// address (completed with errW, never issued). Without it, odd addresses are
// issued unchanged.
// -----------------------------------------------------------------------------
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              validM,
  input  logic [DATA_W-1:0] dataAddrM,
  input  logic [DATA_W-1:0] wrtDataM,
  input  logic              readEnM,
  input  logic              memWrtM,
  input  logic              createDumpM,
  mem_stage_ctrl_if.master  mem,
  output logic              stallM,
  output logic [DATA_W-1:0] memDataW,
  output logic              validW,
  output logic              errW,
  output logic              dumpW
);

  state_t            r_state;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_memDataW;
  logic              r_wr;
  logic              r_validW;
  logic              r_errW;
  logic              r_dumpW;

  logic w_idle;
  logic w_dump;
  logic w_bad_ops;
  logic w_req;
  logic w_misalign;
  logic w_req_ok;
  logic w_issue;
  logic w_wdog_clr;
  logic w_wdog_inc;
  logic w_wdog_tc;

  // Decode the M-stage instruction; a dump request masks any memory request.
  always_comb begin
    w_idle    = (r_state == ST_IDLE);
    w_dump    = validM & createDumpM;
    w_bad_ops = validM & readEnM & memWrtM & ~createDumpM;
    w_req     = validM & is_mem_req(readEnM, memWrtM) & ~createDumpM;
`ifdef MEM_ALIGN_CHECK_EN
    w_misalign = w_req & dataAddrM[0];
`else
    w_misalign = 1'b0;
`endif
    w_req_ok   = w_req & ~w_misalign;
    w_issue    = w_idle & w_req_ok & ~mem.memStall;
    // Watchdog restarts only when an issued access misses.
    w_wdog_clr = w_issue & ~mem.memDone;
    w_wdog_inc = ~w_idle;
  end

  mem_wdog_cnt u_wdog (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_wdog_clr),
    .i_inc (w_wdog_inc),
    .o_tc  (w_wdog_tc)
  );

  // Memory strobes, bus values and pipeline stall for the current cycle.
  always_comb begin
    mem.memEn     = 1'b0;
    mem.memWr     = 1'b0;
    mem.memDump   = 1'b0;
    mem.memAddr   = r_addr;
    mem.memDataIn = r_data;
    stallM        = 1'b0;
    if (rst) begin
      mem.memAddr   = 16'h0000;
      mem.memDataIn = 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          mem.memEn   = w_issue;
          mem.memWr   = w_issue & memWrtM;
          mem.memDump = w_dump;
          if (w_issue) begin
            mem.memAddr   = dataAddrM;
            mem.memDataIn = wrtDataM;
          end else begin
            mem.memAddr   = r_addr;
            mem.memDataIn = r_data;
          end
          // Stall while memory refuses the request, or when it misses.
          stallM = (w_req_ok & mem.memStall) | (w_issue & ~mem.memDone);
        end
        ST_BUSY: begin
          mem.memWr = r_wr;
          // Stall drops on completion or on the watchdog's terminal cycle.
          stallM    = ~mem.memDone & ~w_wdog_tc;
        end
        default: begin
          stallM = 1'b0;
        end
      endcase
    end
  end

  // Controller state, captured request and registered writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= 16'h0000;
      r_data     <= 16'h0000;
      r_wr       <= 1'b0;
      r_memDataW <= 16'h0000;
      r_validW   <= 1'b0;
      r_errW     <= 1'b0;
      r_dumpW    <= 1'b0;
    end else begin
      r_validW <= 1'b0;
      r_errW   <= 1'b0;
      r_dumpW  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_addr <= dataAddrM;
            r_data <= wrtDataM;
            r_wr   <= memWrtM;
            if (mem.memDone) begin
              r_validW   <= 1'b1;
              r_memDataW <= memWrtM ? r_memDataW : mem.memDataOut;
            end else begin
              r_state <= ST_BUSY;
            end
          end else if (validM && !(w_req_ok && mem.memStall)) begin
            // Dump, no-op, conflicting or misaligned op: complete without access.
            r_validW <= 1'b1;
            r_errW   <= w_bad_ops | w_misalign;
            r_dumpW  <= w_dump;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mem.memDone) begin
            r_state    <= ST_IDLE;
            r_validW   <= 1'b1;
            r_memDataW <= r_wr ? r_memDataW : mem.memDataOut;
          end else if (w_wdog_tc) begin
            r_state  <= ST_IDLE;
            r_validW <= 1'b1;
            r_errW   <= 1'b1;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign memDataW = r_memDataW;
  assign validW   = r_validW;
  assign errW     = r_errW;
  assign dumpW    = r_dumpW;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Self-checking bench for mem_stage_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model of the M-stage memory protocol.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        validM;
  logic [15:0] dataAddrM;
  logic [15:0] wrtDataM;
  logic        readEnM;
  logic        memWrtM;
  logic        createDumpM;
  logic        stallM;
  logic [15:0] memDataW;
  logic        validW;
  logic        errW;
  logic        dumpW;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .validM      (validM),
    .dataAddrM   (dataAddrM),
    .wrtDataM    (wrtDataM),
    .readEnM     (readEnM),
    .memWrtM     (memWrtM),
    .createDumpM (createDumpM),
    .mem         (bus),
    .stallM      (stallM),
    .memDataW    (memDataW),
    .validW      (validW),
    .errW        (errW),
    .dumpW       (dumpW)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mdl_stall = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_busy     = 1'b0;  // an issued access is still outstanding
  int          m_age      = 0;     // waiting cycles already spent on it
  bit          m_wr       = 1'b0;
  logic [15:0] m_addr     = 16'h0000;
  logic [15:0] m_data     = 16'h0000;
  bit          m_validW   = 1'b0;
  bit          m_errW     = 1'b0;
  bit          m_dumpW    = 1'b0;
  logic [15:0] m_memDataW = 16'h0000;

  always @(negedge clk) begin : model_cmp
    bit          e_en, e_wr, e_dump, e_stall, chk_bus;
    logic [15:0] e_addr, e_din;
    bit          n_busy, n_wr, n_validW, n_errW, n_dumpW;
    int          n_age;
    logic [15:0] n_addr, n_data, n_memDataW;

    e_en = 1'b0; e_wr = 1'b0; e_dump = 1'b0; e_stall = 1'b0; chk_bus = 1'b0;
    e_addr = m_addr; e_din = m_data;
    n_busy = m_busy; n_age = m_age; n_wr = m_wr; n_addr = m_addr; n_data = m_data;
    n_validW = 1'b0; n_errW = 1'b0; n_dumpW = 1'b0; n_memDataW = m_memDataW;

    if (rst) begin
      chk_bus = 1'b1; e_addr = 16'h0000; e_din = 16'h0000;
      n_busy = 1'b0; n_age = 0; n_wr = 1'b0; n_addr = 16'h0000; n_data = 16'h0000;
      n_memDataW = 16'h0000;
    end else if (m_busy) begin
      chk_bus = 1'b1; e_wr = m_wr;
      if (bus.memDone) begin
        n_busy = 1'b0; n_validW = 1'b1;
        if (!m_wr) n_memDataW = bus.memDataOut;
      end else if (m_age == 255) begin
        n_busy = 1'b0; n_validW = 1'b1; n_errW = 1'b1;
      end else begin
        e_stall = 1'b1; n_age = m_age + 1;
      end
    end else if (validM) begin
      if (createDumpM) begin
        e_dump = 1'b1; n_validW = 1'b1; n_dumpW = 1'b1;
      end else if (readEnM && memWrtM) begin
        n_validW = 1'b1; n_errW = 1'b1;
      end else if (!readEnM && !memWrtM) begin
        n_validW = 1'b1;
      end else if (ALIGN_CHK && dataAddrM[0]) begin
        n_validW = 1'b1; n_errW = 1'b1;
      end else if (bus.memStall) begin
        e_stall = 1'b1;
      end else begin
        e_en = 1'b1; e_wr = memWrtM; e_addr = dataAddrM; e_din = wrtDataM; chk_bus = 1'b1;
        n_addr = dataAddrM; n_data = wrtDataM; n_wr = memWrtM;
        if (bus.memDone) begin
          n_validW = 1'b1;
          if (readEnM) n_memDataW = bus.memDataOut;
        end else begin
          e_stall = 1'b1; n_busy = 1'b1; n_age = 0;
        end
      end
    end

    chk1 ("validW",   validW,      m_validW);
    chk1 ("errW",     errW,        m_errW);
    chk1 ("dumpW",    dumpW,       m_dumpW);
    chk16("memDataW", memDataW,    m_memDataW);
    chk1 ("memEn",    bus.memEn,   e_en);
    chk1 ("memWr",    bus.memWr,   e_wr);
    chk1 ("memDump",  bus.memDump, e_dump);
    chk1 ("stallM",   stallM,      e_stall);
    if (chk_bus) begin
      chk16("memAddr",   bus.memAddr,   e_addr);
      chk16("memDataIn", bus.memDataIn, e_din);
    end

    mdl_stall  = e_stall;
    m_busy     = n_busy;   m_age  = n_age;  m_wr = n_wr;
    m_addr     = n_addr;   m_data = n_data;
    m_validW   = n_validW; m_errW = n_errW; m_dumpW = n_dumpW;
    m_memDataW = n_memDataW;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    validM = 1'b0; readEnM = 1'b0; memWrtM = 1'b0; createDumpM = 1'b0;
    bus.memDone = 1'b0; bus.memStall = 1'b0;
  endtask

  task automatic set_m(input bit rd, input bit wr, input bit dmp,
                       input logic [15:0] a, input logic [15:0] d);
    validM = 1'b1; readEnM = rd; memWrtM = wr; createDumpM = dmp;
    dataAddrM = a; wrtDataM = d;
  endtask

  initial begin : drive
    int stall_cnt;
    int r;
    rst = 1'b1;
    idle_in();
    dataAddrM = 16'h0000; wrtDataM = 16'h0000; bus.memDataOut = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;
    #2;
    chk1 ("reset_stallM",   stallM,      1'b0);
    chk1 ("reset_memEn",    bus.memEn,   1'b0);
    chk1 ("reset_validW",   validW,      1'b0);
    chk16("reset_memDataW", memDataW,    16'h0000);
    chk16("reset_memAddr",  bus.memAddr, 16'h0000);

    // Load hit
    tick(); set_m(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
    bus.memDone = 1'b1; bus.memDataOut = 16'hBEEF;
    #2;
    chk1 ("hit_memEn",   bus.memEn,   1'b1);
    chk1 ("hit_stallM",  stallM,      1'b0);
    chk16("hit_memAddr", bus.memAddr, 16'h0040);
    tick(); idle_in(); #2;
    chk1 ("hit_validW",   validW,   1'b1);
    chk16("hit_memDataW", memDataW, 16'hBEEF);

    // Store, three-cycle miss
    tick(); set_m(1'b0, 1'b1, 1'b0, 16'h0010, 16'h1234); bus.memDone = 1'b0; #2;
    chk1("st_memEn",  bus.memEn, 1'b1);
    chk1("st_memWr",  bus.memWr, 1'b1);
    chk1("st_stallM", stallM,    1'b1);
    for (int c = 1; c <= 3; c++) begin
      tick(); bus.memDone = (c == 3); #2;
      chk1 ("st_busy_memEn",  bus.memEn,     1'b0);
      chk1 ("st_busy_stallM", stallM,        (c == 3) ? 1'b0 : 1'b1);
      chk16("st_busy_addr",   bus.memAddr,   16'h0010);
      chk16("st_busy_data",   bus.memDataIn, 16'h1234);
    end
    tick(); idle_in(); #2;
    chk1 ("st_validW",   validW,   1'b1);
    chk1 ("st_errW",     errW,     1'b0);
    chk16("st_memDataW", memDataW, 16'hBEEF);

    // memStall for two cycles, then a load hit
    for (int c = 0; c <= 2; c++) begin
      tick(); set_m(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
      bus.memStall = (c < 2); bus.memDone = (c == 2); bus.memDataOut = 16'h5A5A; #2;
      chk1("ms_memEn",  bus.memEn, (c == 2) ? 1'b1 : 1'b0);
      chk1("ms_stallM", stallM,    (c < 2)  ? 1'b1 : 1'b0);
    end
    tick(); idle_in(); #2;
    chk1 ("ms_validW",   validW,   1'b1);
    chk16("ms_memDataW", memDataW, 16'h5A5A);

    // Odd-address load
    tick(); set_m(1'b1, 1'b0, 1'b0, 16'h0041, 16'h0000);
    bus.memDone = 1'b1; bus.memDataOut = 16'h0F0F; #2;
    chk1("align_memEn", bus.memEn, ALIGN_CHK ? 1'b0 : 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
    chk1("align_stallM", stallM, 1'b0);
`else
    chk16("align_memAddr", bus.memAddr, 16'h0041);
`endif
    tick(); idle_in(); #2;
    chk1("align_validW", validW, 1'b1);
    chk1("align_errW",   errW,   ALIGN_CHK);

    // Dump with a load also requested: dump wins, no access
    tick(); set_m(1'b1, 1'b0, 1'b1, 16'h0002, 16'h0000); #2;
    chk1("dump_memDump", bus.memDump, 1'b1);
    chk1("dump_memEn",   bus.memEn,   1'b0);
    tick(); idle_in(); #2;
    chk1("dump_dumpW",  dumpW,  1'b1);
    chk1("dump_validW", validW, 1'b1);

    // Load and store together: error completion
    tick(); set_m(1'b1, 1'b1, 1'b0, 16'h0004, 16'h9999); #2;
    chk1("both_memEn", bus.memEn, 1'b0);
    tick(); idle_in(); #2;
    chk1("both_errW",   errW,   1'b1);
    chk1("both_validW", validW, 1'b1);

    // Watchdog: load that never completes
    tick(); set_m(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000); bus.memDone = 1'b0; #2;
    stall_cnt = 0;
    while (stallM === 1'b1 && stall_cnt < 300) begin
      stall_cnt++;
      tick(); #2;
    end
    chk16("wdog_stall_cycles", 16'(stall_cnt), 16'd256);
    tick(); idle_in(); #2;
    chk1("wdog_validW", validW, 1'b1);
    chk1("wdog_errW",   errW,   1'b1);
    chk1("wdog_stallM", stallM, 1'b0);
    tick(); bus.memDone = 1'b1; #2;
    chk1("wdog_late_memEn", bus.memEn, 1'b0);
    tick(); bus.memDone = 1'b0; #2;
    chk1("wdog_late_validW", validW, 1'b0);

    // Reset during an outstanding access, then a late memDone
    tick(); set_m(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0000); bus.memDone = 1'b0;
    repeat (3) tick();
    tick(); rst = 1'b1; idle_in(); #2;
    chk1 ("rstb_stallM",  stallM,      1'b0);
    chk16("rstb_memAddr", bus.memAddr, 16'h0000);
    tick(); rst = 1'b0; bus.memDone = 1'b1; #2;
    chk1("rstb_validW", validW,    1'b0);
    chk1("rstb_memEn",  bus.memEn, 1'b0);
    tick(); bus.memDone = 1'b0; #2;
    chk1("rstb_late_validW", validW, 1'b0);
    chk1("rstb_late_errW",   errW,   1'b0);

    // Randomized traffic; a stalled M-stage instruction stays frozen
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(199) == 0);
      if (rst || !mdl_stall) begin
        r = $urandom_range(15);
        validM      = ($urandom_range(3) != 0);
        createDumpM = (r == 0);
        readEnM     = (r == 1) || (r >= 4 && r < 10);
        memWrtM     = (r == 1) || (r >= 10);
        dataAddrM   = 16'($urandom);
        if ($urandom_range(3) != 0) dataAddrM[0] = 1'b0;
        wrtDataM    = 16'($urandom);
      end
      bus.memStall   = ($urandom_range(3) == 0);
      bus.memDone    = ($urandom_range(2) == 0);
      bus.memDataOut = 16'($urandom);
    end
    tick(); rst = 1'b0; idle_in();
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
